// File: rtl/booth_arith_pkg.sv
// Shared types and width helpers for the sequential Booth multiplier/divider family.
// Holds the divider state encoding and constant functions sized from WIDTH.
package booth_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Bits needed to hold a step count running from WIDTH down to 0.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Two's-complement most-negative value for a given width, zero-extended to 64 bits.
  function automatic logic [63:0] most_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift {rem, quo} left by one, then try to subtract the divisor.
// Purely combinational so the top can register the result once per clock.
module div_restore_step
  import booth_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH+1:0] trial;

  always_comb begin
    rem_shift = {rem, quo[WIDTH-1]};
    // One guard bit above the remainder makes the borrow an explicit sign bit.
    trial     = rem_shift - {2'b00, divisor};
    if (!trial[WIDTH+1]) begin
      rem_next = trial[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/booth_seq_divider.sv
// Sequential signed divider: restoring loop on operand magnitudes, one bit per clock,
// followed by a single sign fix-up cycle that publishes quotient, remainder and flags.
module booth_seq_divider
  import booth_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Qo,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             ovf
);

  localparam int                CW       = count_width(WIDTH);
  localparam logic [WIDTH-1:0]  MOST_NEG = WIDTH'(most_neg(WIDTH));

  div_state_t       state_reg;
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [CW-1:0]    count_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic             dz_pend_reg;
  logic             ovf_pend_reg;

  logic [WIDTH-1:0] n_mag;
  logic [WIDTH-1:0] d_mag;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  // Unsigned magnitudes: negating the most-negative value yields 2^(WIDTH-1), which still fits.
  always_comb begin
    n_mag = N[WIDTH-1] ? -N : N;
    d_mag = D[WIDTH-1] ? -D : D;
  end

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (divisor_reg),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      rem_reg      <= '0;
      quo_reg      <= '0;
      divisor_reg  <= '0;
      count_reg    <= '0;
      sign_q_reg   <= 1'b0;
      sign_r_reg   <= 1'b0;
      dz_pend_reg  <= 1'b0;
      ovf_pend_reg <= 1'b0;
      Qo           <= '0;
      R            <= '0;
      done         <= 1'b0;
      div_by_zero  <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load) begin
            sign_q_reg   <= N[WIDTH-1] ^ D[WIDTH-1];
            sign_r_reg   <= N[WIDTH-1];
            quo_reg      <= n_mag;
            divisor_reg  <= d_mag;
            rem_reg      <= '0;
            count_reg    <= CW'(WIDTH);
            div_by_zero  <= 1'b0;
            ovf          <= 1'b0;
            dz_pend_reg  <= (D == '0);
            ovf_pend_reg <= (N == MOST_NEG) && (D == '1);
            state_reg    <= (D == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          rem_reg   <= rem_next;
          quo_reg   <= quo_next;
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          if (dz_pend_reg) begin
            // quo still holds |N|, so re-applying the dividend sign recovers N exactly.
            Qo <= '1;
            R  <= sign_r_reg ? -quo_reg : quo_reg;
          end else begin
            Qo <= sign_q_reg ? -quo_reg : quo_reg;
            R  <= sign_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
          end
          div_by_zero <= dz_pend_reg;
          ovf         <= ovf_pend_reg;
          done        <= 1'b1;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed bench for booth_seq_divider at WIDTH=4 with hand-computed quotients and remainders.
module tb_booth_seq_divider;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] N;
  logic [3:0] D;
  logic [3:0] Qo;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic       ovf;

  int tests = 0;
  int fails = 0;

  booth_seq_divider #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .N           (N),
    .D           (D),
    .Qo          (Qo),
    .R           (R),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Returns at the falling edge just after the accepting rising edge.
  task automatic start(input logic [3:0] n, input logic [3:0] d);
    @(negedge clk);
    N = n; D = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Counts falling edges from the one after the load edge until done; -1 if it never comes.
  task automatic wait_done(input int k0, output int lat, output int busy_cycles, output int q_changed);
    logic [3:0] q_first;
    lat = -1; busy_cycles = 0; q_changed = 0;
    q_first = Qo;
    for (int k = k0; k < 40; k++) begin
      if (k > k0) @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cycles++;
      if (Qo !== q_first) q_changed = 1;
    end
  endtask

  task automatic run(input string tag, input logic [3:0] n, input logic [3:0] d, input int exp_lat,
                     input logic [3:0] exp_q, input logic [3:0] exp_r, input logic exp_dz, input logic exp_ovf);
    int lat, bc, qc;
    start(n, d);
    check({tag, "_flags_cleared"}, {30'd0, div_by_zero, ovf}, 32'd0);
    wait_done(0, lat, bc, qc);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, bc, exp_lat);
    check({tag, "_q_hold"}, qc, 0);
    check({tag, "_q"}, Qo, exp_q);
    check({tag, "_r"}, R, exp_r);
    check({tag, "_dz_ovf"}, {div_by_zero, ovf}, {exp_dz, exp_ovf});
    $display("[TB] %s N=%h D=%h -> Qo=%h R=%h dz=%b ovf=%b lat=%0d", tag, n, d, Qo, R, div_by_zero, ovf, lat);
  endtask

  initial begin
    int lat, bc, qc, seen;
    reset = 1'b1; load = 1'b0; N = 4'h0; D = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {Qo, R, busy, done, div_by_zero, ovf}, 32'd0);
    reset = 1'b0;

    run("p7_p2",   4'h7, 4'h2, 5, 4'h3, 4'h1, 1'b0, 1'b0);
    run("m7_p2",   4'h9, 4'h2, 5, 4'hD, 4'hF, 1'b0, 1'b0);
    run("p7_m2",   4'h7, 4'hE, 5, 4'hD, 4'h1, 1'b0, 1'b0);
    run("m7_m2",   4'h9, 4'hE, 5, 4'h3, 4'hF, 1'b0, 1'b0);
    run("m8_m1",   4'h8, 4'hF, 5, 4'h8, 4'h0, 1'b0, 1'b1);
    run("m8_p1",   4'h8, 4'h1, 5, 4'h8, 4'h0, 1'b0, 1'b0);
    run("p5_zero", 4'h5, 4'h0, 1, 4'hF, 4'h5, 1'b1, 1'b0);
    run("p6_p3",   4'h6, 4'h3, 5, 4'h2, 4'h0, 1'b0, 1'b0);
    run("m8_zero", 4'h8, 4'h0, 1, 4'hF, 4'h8, 1'b1, 1'b0);
    run("p3_p7",   4'h3, 4'h7, 5, 4'h0, 4'h3, 1'b0, 1'b0);

    // Load while busy must be ignored.
    start(4'h6, 4'h3);
    @(negedge clk);
    N = 4'h7; D = 4'h1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_done(2, lat, bc, qc);
    check("ignored_latency", lat, 5);
    check("ignored_q", Qo, 4'h2);
    check("ignored_r", R, 4'h0);
    $display("[TB] ignored-load 6/3 (7/1 mid-flight) -> Qo=%h R=%h lat=%0d", Qo, R, lat);

    // Back-to-back: load raised in the done cycle is accepted.
    N = 4'h7; D = 4'h2; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("b2b_busy", busy, 1'b1);
    wait_done(0, lat, bc, qc);
    check("b2b_latency", lat, 5);
    check("b2b_q", Qo, 4'h3);
    check("b2b_r", R, 4'h1);
    $display("[TB] back-to-back 7/2 -> Qo=%h R=%h lat=%0d", Qo, R, lat);

    // Reset mid-operation aborts without a done pulse.
    start(4'h7, 4'h2);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_outputs", {Qo, R, busy, done, div_by_zero, ovf}, 32'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("abort_no_done", seen, 0);
    $display("[TB] reset mid-op -> busy=%b Qo=%h R=%h", busy, Qo, R);

    // Reset wins over a simultaneous load.
    @(negedge clk);
    reset = 1'b1; load = 1'b1; N = 4'h7; D = 4'h2;
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    check("rst_load_busy", busy, 1'b0);
    @(negedge clk);
    check("rst_load_idle", {busy, done}, 2'b00);
    $display("[TB] reset+load -> busy=%b done=%b", busy, done);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
